// File: rtl/alu_mdu.sv
// alu_mdu: registered single-cycle ALU plus iterative unsigned multiply/divide unit.
// Single-cycle ops complete on the accepting edge; MUL/DIV run DATA_W steps behind busy.
module alu_mdu #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        op_type,
  input  logic [1:0]        arith_sel,
  input  logic [1:0]        logic_sel,
  input  logic [3:0]        shift_sel,
  input  logic [DATA_W-1:0] operand1,
  input  logic [DATA_W-1:0] operand2,
  output logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] result_hi,
  output logic              busy,
  output logic              done,
  input  logic [3:0]        flag_din,
  input  logic              flag_wr,
  output logic              flag_z,
  output logic              flag_c,
  output logic              flag_n,
  output logic              flag_v
);
  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam int H = DATA_W / 2;
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;
  state_t state_q;
  logic busy_q, done_q, mul_q, dz_q;
  logic z_q, c_q, n_q, v_q;
  logic [DATA_W-1:0] res_q, hi_q, opa_q;
  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q;
  logic [DATA_W-1:0] b, lgc, shf, alu_res;
  logic [DATA_W:0] sum, msum, t, r;
  logic cin, lbot, rtop, alu_c, alu_v, alu_z, ge;
  always_comb begin
    b = arith_sel[1] ? ~operand2 : operand2;
    cin = arith_sel[0] ? arith_sel[1] ^ c_q : arith_sel[1];
    sum = {1'b0, operand1} + {1'b0, b} + (DATA_W+1)'(cin);
    lgc = logic_sel == 2'd0 ? operand1 & operand2 :
          logic_sel == 2'd1 ? operand1 | operand2 :
          logic_sel == 2'd2 ? operand1 ^ operand2 : {operand1[H-1:0], operand1[DATA_W-1:H]};
    lbot = shift_sel[1] ? (shift_sel[2] ? c_q : operand1[DATA_W-1]) : shift_sel[2] & c_q;
    rtop = shift_sel[1] ? (shift_sel[2] ? c_q : operand1[0]) :
           shift_sel[3] ? operand1[DATA_W-1] : shift_sel[2] & c_q;
    shf = shift_sel[0] ? {rtop, operand1[DATA_W-1:1]} : {operand1[DATA_W-2:0], lbot};
    alu_res = op_type == 3'd1 ? sum[DATA_W-1:0] : op_type == 3'd2 ? lgc :
              op_type == 3'd3 ? shf : operand2;
    alu_c = op_type == 3'd1 ? arith_sel[1] ^ sum[DATA_W] :
            op_type == 3'd3 ? (shift_sel[0] ? operand1[0] : operand1[DATA_W-1]) : c_q;
    alu_v = op_type == 3'd1 ? (operand1[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != operand1[DATA_W-1]) : v_q;
    // SBC chains fold the previous Z in so multi-word compares yield a whole-word zero test
    alu_z = (alu_res == '0) & (!(op_type == 3'd1 && arith_sel == 2'b11) | z_q);
    msum = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + {1'b0, acc_q[0] ? opa_q : '0};
    t = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
    ge = t >= {1'b0, opa_q};
    r = ge ? t - {1'b0, opa_q} : t;
    acc_d = mul_q ? {msum, acc_q[DATA_W-1:1]} : {r[DATA_W-1:0], acc_q[DATA_W-2:0], ge};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      mul_q <= 1'b0;
      dz_q <= 1'b0;
      res_q <= '0;
      hi_q <= '0;
      opa_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      {v_q, n_q, c_q, z_q} <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          if (op_type == 3'd4 || op_type == 3'd5) begin
            busy_q <= 1'b1;
            mul_q <= op_type == 3'd4;
            dz_q <= op_type == 3'd5 && operand2 == '0;
            opa_q <= op_type == 3'd4 ? operand1 : operand2;
            acc_q <= {{DATA_W{1'b0}}, op_type == 3'd4 ? operand2 : operand1};
            cnt_q <= CNT_W'(DATA_W - 1);
            state_q <= op_type == 3'd4 ? MUL : operand2 == '0 ? FIN : DIV;
          end else begin
            res_q <= alu_res;
            hi_q <= '0;
            done_q <= 1'b1;
            if (op_type inside {3'd1, 3'd2, 3'd3})
              {v_q, n_q, c_q, z_q} <= {alu_v, alu_res[DATA_W-1], alu_c, alu_z};
          end
        end
        MUL, DIV: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_q <= FIN;
        end
        FIN: begin
          // last step happens here, so partial values never reach result/result_hi
          state_q <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
          res_q <= dz_q ? '1 : acc_d[DATA_W-1:0];
          hi_q <= dz_q ? acc_q[DATA_W-1:0] : acc_d[2*DATA_W-1:DATA_W];
          z_q <= !dz_q && (mul_q ? acc_d == '0 : acc_d[DATA_W-1:0] == '0);
          n_q <= dz_q | acc_d[DATA_W-1];
          c_q <= mul_q && acc_d[2*DATA_W-1:DATA_W] != '0;
          v_q <= dz_q;
        end
      endcase
      if (flag_wr) {v_q, n_q, c_q, z_q} <= flag_din;
    end
  end
  assign result = res_q;
  assign result_hi = hi_q;
  assign busy = busy_q;
  assign done = done_q;
  assign {flag_v, flag_n, flag_c, flag_z} = {v_q, n_q, c_q, z_q};
endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: directed vectors for alu_mdu at DATA_W=8, plus a DATA_W=16 multiply.
module tb_alu_mdu;
  logic clk = 1'b0, rst_n, start, start16, flag_wr;
  logic [2:0] op_type;
  logic [1:0] arith_sel, logic_sel;
  logic [3:0] shift_sel, flag_din;
  logic [7:0] operand1, operand2, result, result_hi;
  logic [15:0] a16, b16, r16, h16;
  logic busy, done, fz, fc, fn, fv, busy16, done16, z16, c16, n16, v16;
  logic [3:0] fl, fl16;
  int total = 0, bad = 0, lat, bsy, cnt;

  assign fl = {fv, fn, fc, fz};
  assign fl16 = {v16, n16, c16, z16};

  alu_mdu #(.DATA_W(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start), .op_type(op_type), .arith_sel(arith_sel),
    .logic_sel(logic_sel), .shift_sel(shift_sel), .operand1(operand1), .operand2(operand2),
    .result(result), .result_hi(result_hi), .busy(busy), .done(done), .flag_din(flag_din),
    .flag_wr(flag_wr), .flag_z(fz), .flag_c(fc), .flag_n(fn), .flag_v(fv));

  alu_mdu #(.DATA_W(16)) u16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .op_type(op_type), .arith_sel(arith_sel),
    .logic_sel(logic_sel), .shift_sel(shift_sel), .operand1(a16), .operand2(b16),
    .result(r16), .result_hi(h16), .busy(busy16), .done(done16), .flag_din(flag_din),
    .flag_wr(flag_wr), .flag_z(z16), .flag_c(c16), .flag_n(n16), .flag_v(v16));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic alu(input logic [2:0] op, input logic [1:0] as, input logic [1:0] ls,
                     input logic [3:0] ss, input logic [7:0] a, input logic [7:0] b);
    op_type = op; arith_sel = as; logic_sel = ls; shift_sel = ss;
    operand1 = a; operand2 = b; start = 1'b1;
    tick;
  endtask

  task automatic go(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    op_type = op; operand1 = a; operand2 = b; start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  // n counts cycles since the accepting edge; optional ignored start / flag write injected
  task automatic wait_done(input int inj_start, input int inj_fw, output int n, output int nb);
    n = 1; nb = 0;
    while (!done && n < 40) begin
      if (busy) nb++;
      start = (n == inj_start);
      if (n == inj_start) begin op_type = 3'd1; operand1 = 8'd1; operand2 = 8'd1; end
      flag_wr = (n == inj_fw);
      flag_din = 4'b1010;
      tick;
      n++;
    end
    start = 1'b0; flag_wr = 1'b0;
  endtask

  task automatic fwrite(input logic [3:0] f);
    start = 1'b0; flag_wr = 1'b1; flag_din = f;
    tick;
    flag_wr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; start16 = 1'b0; flag_wr = 1'b0; flag_din = '0;
    op_type = '0; arith_sel = '0; logic_sel = '0; shift_sel = '0;
    operand1 = '0; operand2 = '0; a16 = '0; b16 = '0;
    tick; tick;
    chk("rst_res", result, 8'h00);
    chk("rst_hi", result_hi, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_flags", fl, 4'b0000);
    rst_n = 1'b1;

    alu(3'd1, 2'b00, 2'd0, 4'd0, 8'h7F, 8'h01);
    start = 1'b0;
    chk("add_res", result, 8'h80);
    chk("add_done", done, 1'b1);
    chk("add_busy", busy, 1'b0);
    chk("add_flags", fl, 4'b1100);
    tick;
    chk("add_pulse", done, 1'b0);

    go(3'd4, 8'd200, 8'd3);
    wait_done(3, 0, lat, bsy);
    chk("mul_lat", lat, 9);
    chk("mul_busy_cyc", bsy, 8);
    chk("mul_busy_end", busy, 1'b0);
    chk("mul_lo", result, 8'h58);
    chk("mul_hi", result_hi, 8'h02);
    chk("mul_flags", fl, 4'b0010);
    tick;
    chk("mul_pulse", done, 1'b0);
    chk("mul_noqueue", result, 8'h58);

    go(3'd5, 8'd100, 8'd7);
    wait_done(0, 0, lat, bsy);
    chk("div_lat", lat, 9);
    chk("div_q", result, 8'd14);
    chk("div_r", result_hi, 8'd2);
    chk("div_flags", fl, 4'b0000);
    go(3'd5, 8'd5, 8'd0);
    wait_done(0, 0, lat, bsy);
    chk("dz_lat", lat, 2);
    chk("dz_q", result, 8'hFF);
    chk("dz_r", result_hi, 8'h05);
    chk("dz_flags", fl, 4'b1100);

    alu(3'd1, 2'b10, 2'd0, 4'd0, 8'h34, 8'h34);
    chk("sub_res", result, 8'h00);
    chk("sub_hi0", result_hi, 8'h00);
    chk("sub_flags", fl, 4'b0001);
    alu(3'd1, 2'b11, 2'd0, 4'd0, 8'h12, 8'h13);
    chk("sbc_res", result, 8'hFF);
    chk("sbc_flags", fl, 4'b0110);
    alu(3'd1, 2'b10, 2'd0, 4'd0, 8'h34, 8'h34);
    alu(3'd1, 2'b11, 2'd0, 4'd0, 8'h12, 8'h12);
    chk("sbc0_res", result, 8'h00);
    chk("sbc0_flags", fl, 4'b0001);
    alu(3'd1, 2'b10, 2'd0, 4'd0, 8'h34, 8'h35);
    chk("subb_flags", fl, 4'b0110);
    alu(3'd1, 2'b11, 2'd0, 4'd0, 8'h12, 8'h11);
    chk("zacc_res", result, 8'h00);
    chk("zacc_flags", fl, 4'b0000);
    chk("b2b_done", done, 1'b1);

    fwrite(4'b1010);
    chk("fwr_flags", fl, 4'b1010);
    alu(3'd2, 2'b00, 2'd2, 4'd0, 8'hF0, 8'h3C);
    chk("xor_res", result, 8'hCC);
    chk("xor_flags", fl, 4'b1110);
    alu(3'd2, 2'b00, 2'd3, 4'd0, 8'hA5, 8'h00);
    chk("swap_res", result, 8'h5A);
    chk("swap_flags", fl, 4'b1010);
    alu(3'd0, 2'b00, 2'd0, 4'd0, 8'h77, 8'h00);
    chk("mov_res", result, 8'h00);
    chk("mov_flags", fl, 4'b1010);
    alu(3'd7, 2'b00, 2'd0, 4'd0, 8'h77, 8'h33);
    chk("mov7_res", result, 8'h33);

    fwrite(4'b0010);
    alu(3'd3, 2'b00, 2'd0, 4'b1001, 8'h81, 8'h00);
    chk("asr_res", result, 8'hC0);
    chk("asr_flags", fl, 4'b0110);
    alu(3'd3, 2'b00, 2'd0, 4'b0110, 8'h80, 8'h00);
    chk("rolc_res", result, 8'h01);
    chk("rolc_flags", fl, 4'b0010);
    alu(3'd3, 2'b00, 2'd0, 4'b0000, 8'h80, 8'h00);
    chk("shl_res", result, 8'h00);
    chk("shl_flags", fl, 4'b0011);
    alu(3'd3, 2'b00, 2'd0, 4'b0011, 8'h01, 8'h00);
    chk("ror_res", result, 8'h80);
    chk("ror_flags", fl, 4'b0110);
    start = 1'b0;

    go(3'd4, 8'd200, 8'd3);
    wait_done(0, 8, lat, bsy);
    chk("fwc_lat", lat, 9);
    chk("fwc_res", result, 8'h58);
    chk("fwc_flags", fl, 4'b1010);

    go(3'd4, 8'd200, 8'd3);
    tick; tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_res", result, 8'h00);
    chk("abort_hi", result_hi, 8'h00);
    chk("abort_flags", fl, 4'b0000);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) cnt++;
      tick;
    end
    chk("abort_nodone", cnt, 0);
    alu(3'd1, 2'b00, 2'd0, 4'd0, 8'h01, 8'h01);
    start = 1'b0;
    chk("post_add", result, 8'h02);
    chk("post_done", done, 1'b1);

    op_type = 3'd4; a16 = 16'hFFFF; b16 = 16'hFFFF; start16 = 1'b1;
    tick;
    start16 = 1'b0;
    lat = 1;
    while (!done16 && lat < 60) begin
      tick;
      lat++;
    end
    chk("w16_lat", lat, 17);
    chk("w16_lo", r16, 16'h0001);
    chk("w16_hi", h16, 16'hFFFE);
    chk("w16_flags", fl16, 4'b0010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
